// File: rtl/conv3x3_scheduler_if.sv
// conv3x3_scheduler_if
//   Bundles the control handshake (start/abort/kernel/busy/done) and the
//   single-port SRAM bus of the 3x3 convolution scheduler.
//   master : the scheduler (drives SRAM bus, busy, done)
//   slave  : the environment (drives start/abort/kernel, returns sram_dout)
//   Signals:
//     start     1   one-cycle pulse, begins a pass when idle
//     abort     1   synchronous abort of a running pass
//     kernel    36  nine signed 4-bit weights, tap k at [4k+3:4k]
//     busy      1   high while a pass is running
//     done      1   one-cycle pulse at end of a completed pass
//     sram_csn  1   chip select, active low
//     sram_wen  1   1 = write, 0 = read
//     sram_a    AW  word address
//     sram_din  16  write data
//     sram_dout 16  read data, valid the cycle after the address
interface conv3x3_scheduler_if #(
  parameter int AW = 19
) ();
  logic          start;
  logic          abort;
  logic [35:0]   kernel;
  logic          busy;
  logic          done;
  logic          sram_csn;
  logic          sram_wen;
  logic [AW-1:0] sram_a;
  logic [15:0]   sram_din;
  logic [15:0]   sram_dout;

  modport master (
    input  start, abort, kernel, sram_dout,
    output busy, done, sram_csn, sram_wen, sram_a, sram_din
  );

  modport slave (
    output start, abort, kernel, sram_dout,
    input  busy, done, sram_csn, sram_wen, sram_a, sram_din
  );
endinterface

// File: rtl/conv3x3_scheduler.sv
// conv3x3_scheduler
//   Runs a full 3x3 convolution pass over the image stored at word 0 of a
//   single-port SRAM and writes clamped results for every interior pixel to
//   the output region starting at OUT_BASE. Each pixel costs 11 cycles:
//   nine tap reads, one drain cycle for the last read, one write.
//   Ports:
//     clk  clock
//     rst  asynchronous, active-high reset
//     bus  conv3x3_scheduler_if.master (control handshake + SRAM bus)
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | SRAM deselected, waiting for start
//   ST_READ  | tap k address on the bus; accumulate data of tap k-1
//   ST_LAST  | SRAM deselected; accumulate data of tap 8
//   ST_WRITE | write clamped, scaled sum; advance to next pixel
//   ST_DONE  | one-cycle done pulse, then back to idle
module conv3x3_scheduler #(
  parameter int IMG_W    = 512,
  parameter int IMG_H    = 512,
  parameter int AW       = 19,
  parameter int OUT_BASE = 262144,
  parameter int SHIFT    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  conv3x3_scheduler_if.master  bus
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  typedef enum logic [2:0] {ST_IDLE, ST_READ, ST_LAST, ST_WRITE, ST_DONE} state_t;

  state_t               state_q;
  logic [3:0]           k_q;
  logic [XW-1:0]        x_q;
  logic [YW-1:0]        y_q;
  logic signed [23:0]   acc_q;
  logic [35:0]          w_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 csn_q;
  logic                 wen_q;
  logic [AW-1:0]        a_q;
  logic [15:0]          din_q;

  logic [3:0]           wsel;
  logic signed [3:0]    w_cur;
  logic signed [20:0]   dout_s;
  logic signed [20:0]   w_s;
  logic signed [20:0]   prod;
  logic signed [23:0]   acc_d;
  logic signed [23:0]   shifted;
  logic [15:0]          din_d;
  logic                 last_col;
  logic                 last_px;
  logic [XW-1:0]        x_d;
  logic [YW-1:0]        y_d;

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sram_csn = csn_q;
  assign bus.sram_wen = wen_q;
  assign bus.sram_a   = a_q;
  assign bus.sram_din = din_q;

  // Word address of tap k around pixel (x, y); rows are IMG_W apart.
  function automatic logic [AW-1:0] tap_addr(input logic [3:0] k,
                                             input logic [XW-1:0] x,
                                             input logic [YW-1:0] y);
    logic [1:0]    dr;
    logic [1:0]    dc;
    logic [AW-1:0] row;
    case (k)
      4'd0:    {dr, dc} = 4'b0000;
      4'd1:    {dr, dc} = 4'b0001;
      4'd2:    {dr, dc} = 4'b0010;
      4'd3:    {dr, dc} = 4'b0100;
      4'd4:    {dr, dc} = 4'b0101;
      4'd5:    {dr, dc} = 4'b0110;
      4'd6:    {dr, dc} = 4'b1000;
      4'd7:    {dr, dc} = 4'b1001;
      4'd8:    {dr, dc} = 4'b1010;
      default: {dr, dc} = 4'b0000;
    endcase
    row = AW'(y) + AW'(dr) - AW'(1);
    return (row << XW) + AW'(x) + AW'(dc) - AW'(1);
  endfunction

  // The data on sram_dout belongs to the previous tap, hence k-1 in READ
  // and tap 8 in LAST.
  always_comb begin
    wsel  = (state_q == ST_LAST) ? 4'd8 : (k_q - 4'd1);
    w_cur = '0;
    for (int i = 0; i < 9; i++) begin
      if (wsel == 4'(i)) w_cur = w_q[4*i +: 4];
    end
    dout_s  = {5'b0, bus.sram_dout};
    w_s     = {{17{w_cur[3]}}, w_cur};
    prod    = dout_s * w_s;
    acc_d   = acc_q + $signed({{3{prod[20]}}, prod});
    shifted = acc_d >>> SHIFT;
    if (shifted < 0)
      din_d = '0;
    else if (shifted > 24'sd65535)
      din_d = 16'hFFFF;
    else
      din_d = shifted[15:0];
  end

  always_comb begin
    last_col = (x_q == XW'(IMG_W - 2));
    last_px  = last_col && (y_q == YW'(IMG_H - 2));
    x_d      = last_col ? XW'(1) : x_q + XW'(1);
    y_d      = last_col ? y_q + YW'(1) : y_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      x_q     <= XW'(1);
      y_q     <= YW'(1);
      acc_q   <= '0;
      w_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      csn_q   <= 1'b1;
      wen_q   <= 1'b0;
      a_q     <= '0;
      din_q   <= '0;
    end else begin
      done_q <= 1'b0;
      // busy_q is high exactly in READ/LAST/WRITE. A write already on the
      // bus completes at this edge, so aborting from WRITE loses nothing.
      if (busy_q && bus.abort) begin
        state_q <= ST_IDLE;
        k_q     <= '0;
        x_q     <= XW'(1);
        y_q     <= YW'(1);
        acc_q   <= '0;
        busy_q  <= 1'b0;
        csn_q   <= 1'b1;
        wen_q   <= 1'b0;
        a_q     <= '0;
        din_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bus.start) begin
              w_q     <= bus.kernel;
              k_q     <= '0;
              acc_q   <= '0;
              busy_q  <= 1'b1;
              csn_q   <= 1'b0;
              wen_q   <= 1'b0;
              a_q     <= tap_addr(4'd0, x_q, y_q);
              din_q   <= '0;
              state_q <= ST_READ;
            end
          end
          ST_READ: begin
            if (k_q != 4'd0) acc_q <= acc_d;
            if (k_q == 4'd8) begin
              csn_q   <= 1'b1;
              a_q     <= '0;
              state_q <= ST_LAST;
            end else begin
              k_q <= k_q + 4'd1;
              a_q <= tap_addr(k_q + 4'd1, x_q, y_q);
            end
          end
          ST_LAST: begin
            acc_q   <= acc_d;
            csn_q   <= 1'b0;
            wen_q   <= 1'b1;
            a_q     <= AW'(OUT_BASE) + (AW'(y_q) << XW) + AW'(x_q);
            din_q   <= din_d;
            state_q <= ST_WRITE;
          end
          ST_WRITE: begin
            wen_q <= 1'b0;
            din_q <= '0;
            acc_q <= '0;
            k_q   <= '0;
            if (last_px) begin
              x_q     <= XW'(1);
              y_q     <= YW'(1);
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              csn_q   <= 1'b1;
              a_q     <= '0;
              state_q <= ST_DONE;
            end else begin
              x_q     <= x_d;
              y_q     <= y_d;
              csn_q   <= 1'b0;
              a_q     <= tap_addr(4'd0, x_d, y_d);
              state_q <= ST_READ;
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_scheduler.sv
`timescale 1ns/1ps
module tb_conv3x3_scheduler;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int AW = 7;
  localparam int OB = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv3x3_scheduler_if #(.AW(AW)) bus0 ();
  conv3x3_scheduler_if #(.AW(AW)) bus1 ();

  conv3x3_scheduler #(.IMG_W(W), .IMG_H(H), .AW(AW), .OUT_BASE(OB), .SHIFT(0))
    u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  conv3x3_scheduler #(.IMG_W(W), .IMG_H(H), .AW(AW), .OUT_BASE(OB), .SHIFT(3))
    u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Selects which scheduler owns the SRAM model for the current test.
  logic use1;
  logic m_csn, m_wen, m_busy, m_done;
  logic [AW-1:0] m_a;
  logic [15:0]   m_din;
  always_comb begin
    if (use1) begin
      m_csn = bus1.sram_csn; m_wen = bus1.sram_wen; m_busy = bus1.busy;
      m_done = bus1.done;    m_a = bus1.sram_a;     m_din = bus1.sram_din;
    end else begin
      m_csn = bus0.sram_csn; m_wen = bus0.sram_wen; m_busy = bus0.busy;
      m_done = bus0.done;    m_a = bus0.sram_a;     m_din = bus0.sram_din;
    end
  end

  logic [15:0] mem [0:127];
  logic [15:0] rdata;
  logic        fill_req;
  int          fill_mode;
  assign bus0.sram_dout = rdata;
  assign bus1.sram_dout = rdata;

  // Image words 0..63 hold the pattern; the output region holds a sentinel.
  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < 128; i++)
        mem[i] <= (i >= OB) ? 16'hDEAD :
                  (fill_mode == 0) ? 16'(i) :
                  (fill_mode == 1) ? 16'hFFFF : 16'd16;
    end else if (!m_csn) begin
      if (m_wen) mem[m_a] <= m_din;
      else       rdata    <= mem[m_a];
    end
  end

  logic [AW+15:0] exp_q [$];
  int busy_cyc = 0;
  int done_cnt = 0;
  int wr_cnt   = 0;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops one expected (addr,data) per observed SRAM write.
  always @(negedge clk) begin
    logic [AW+15:0] e;
    if (m_busy) busy_cyc++;
    if (m_done) done_cnt++;
    if (!m_csn && m_wen) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, required no write", m_a, m_din);
      end else begin
        e = exp_q.pop_front();
        check("sram_write {addr,data}", 32'({m_a, m_din}), 32'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input logic v);
    if (use1) bus1.start = v; else bus0.start = v;
  endtask

  task automatic set_abort(input logic v);
    if (use1) bus1.abort = v; else bus0.abort = v;
  endtask

  task automatic set_kernel(input logic [35:0] k);
    bus0.kernel = k;
    bus1.kernel = k;
  endtask

  task automatic fill(input int mode);
    fill_mode = mode;
    fill_req  = 1'b1;
    tick();
    fill_req  = 1'b0;
  endtask

  // mode 0: identity result (output equals image word); else constant cval.
  task automatic push_exp(input int mode, input logic [15:0] cval, input int npix);
    int n;
    n = 0;
    for (int y = 1; y <= H - 2; y++)
      for (int x = 1; x <= W - 2; x++) begin
        if (n < npix)
          exp_q.push_back({AW'(OB + y*W + x), (mode == 0) ? 16'(y*W + x) : cval});
        n++;
      end
  endtask

  task automatic run_pass(input logic [35:0] kern, input int restart_at,
                          input int abort_at, input bit trace, input string tag);
    int b0, d0;
    bit seen;
    int exp_a [9];
    exp_a = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
    b0 = busy_cyc;
    d0 = done_cnt;
    seen = 1'b0;
    set_kernel(kern);
    set_start(1'b1);
    tick();
    set_start(1'b0);
    check({tag, " busy_rise"}, 32'(m_busy), 32'd1);
    for (int c = 0; c < 2000 && !seen; c++) begin
      if (trace && c < 9) begin
        check("trace_rd_addr", 32'(m_a), 32'(exp_a[c]));
        check("trace_rd_csn_wen", 32'({m_csn, m_wen}), 32'b00);
      end
      if (trace && c == 9) check("trace_gap_csn", 32'(m_csn), 32'd1);
      if (trace && c == 10) begin
        check("trace_wr_addr", 32'(m_a), 32'(OB + 9));
        check("trace_wr_csn_wen", 32'({m_csn, m_wen}), 32'b01);
      end
      if (c == restart_at) begin
        set_start(1'b1);
        set_kernel(36'h777777777);
      end
      if (c == abort_at) begin
        set_abort(1'b1);
        tick();
        set_abort(1'b0);
        check({tag, " abort_next_csn"}, 32'(m_csn), 32'd1);
        check({tag, " abort_next_busy"}, 32'(m_busy), 32'd0);
        return;
      end
      tick();
      set_start(1'b0);
      if (m_done) seen = 1'b1;
    end
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    check({tag, " busy_cycles"}, 32'(busy_cyc - b0), 32'd396);
    tick();
    check({tag, " done_pulses"}, 32'(done_cnt - d0), 32'd1);
    check({tag, " idle_after_done"}, 32'({m_busy, m_csn}), 32'b01);
    check({tag, " queue_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int err, d0, w0;
    rst = 1'b1;
    use1 = 1'b0;
    fill_req = 1'b0;
    fill_mode = 0;
    bus0.start = 1'b0; bus0.abort = 1'b0;
    bus1.start = 1'b0; bus1.abort = 1'b0;
    set_kernel('0);
    tick();
    tick();
    check("reset busy", 32'(bus0.busy), 32'd0);
    check("reset done", 32'(bus0.done), 32'd0);
    check("reset csn/wen", 32'({bus0.sram_csn, bus0.sram_wen}), 32'b10);
    check("reset addr", 32'(bus0.sram_a), 32'd0);
    check("reset din", 32'(bus0.sram_din), 32'd0);
    rst = 1'b0;
    tick();

    // Identity kernel with address trace and border check.
    fill(0);
    push_exp(0, 16'd0, 36);
    run_pass(36'h000010000, -1, -1, 1'b1, "identity");
    err = 0;
    for (int a = 0; a < 64; a++)
      if ((a % 8) == 0 || (a % 8) == 7 || (a / 8) == 0 || (a / 8) == 7)
        if (mem[OB + a] !== 16'hDEAD) err++;
    check("border_untouched", 32'(err), 32'd0);

    // Positive saturation and negative clamp.
    fill(1);
    push_exp(1, 16'hFFFF, 36);
    run_pass(36'h777777777, -1, -1, 1'b0, "sat_high");
    fill(1);
    push_exp(1, 16'h0000, 36);
    run_pass(36'h000080000, -1, -1, 1'b0, "sat_low");

    // Scaling on the SHIFT=3 instance: 9*16 = 144, >>> 3 = 18.
    use1 = 1'b1;
    fill(2);
    push_exp(1, 16'd18, 36);
    run_pass(36'h111111111, -1, -1, 1'b0, "scale");
    use1 = 1'b0;

    // Second start (with a new kernel) at pixel 5 is ignored.
    fill(0);
    push_exp(0, 16'd0, 36);
    run_pass(36'h000010000, 5*11 + 2, -1, 1'b0, "restart");

    // Abort during READ k=4 of pixel 3 (0-based, pixel (4,1)).
    fill(0);
    push_exp(0, 16'd0, 3);
    d0 = done_cnt;
    run_pass(36'h000010000, -1, 3*11 + 4, 1'b0, "abort");
    repeat (30) tick();
    check("abort no_done", 32'(done_cnt - d0), 32'd0);
    check("abort idle", 32'({m_busy, m_csn}), 32'b01);
    check("abort pixel3_unwritten", 32'(mem[OB + 12]), 32'hDEAD);
    check("abort queue_drained", 32'(exp_q.size()), 32'd0);
    fill(0);
    push_exp(0, 16'd0, 36);
    run_pass(36'h000010000, -1, -1, 1'b0, "after_abort");

    // Reset asserted in the WRITE cycle of the first pixel.
    fill(0);
    set_kernel(36'h000010000);
    d0 = done_cnt;
    w0 = wr_cnt;
    set_start(1'b1);
    tick();
    set_start(1'b0);
    repeat (10) tick();
    check("rst pre_write csn/wen", 32'({m_csn, m_wen}), 32'b01);
    rst = 1'b1;
    #1;
    check("rst same_cycle csn/wen/busy", 32'({m_csn, m_wen, m_busy}), 32'b100);
    tick();
    rst = 1'b0;
    repeat (20) tick();
    check("rst stays_idle", 32'({m_busy, m_csn}), 32'b01);
    check("rst no_writes", 32'(wr_cnt - w0), 32'd0);
    check("rst no_done", 32'(done_cnt - d0), 32'd0);
    check("rst pixel0_unwritten", 32'(mem[OB + 9]), 32'hDEAD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
